adc_fifo_drain_packer: RTL and testbench

// Drains a fixed-length capture of 12-bit ADC samples from one channel's async sample FIFO.

---
 rtl/adc_fifo_drain_packer.sv | 115 +++++++++++
 tb/tb_adc_fifo_drain_packer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_fifo_drain_packer.sv
// Drains a fixed-length capture of ADC samples from a channel FIFO (read latency 1)
// and packs two samples per 32-bit word onto an AXI-Stream-style master port.
module adc_fifo_drain_packer #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  num_samples,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_not_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [31:0]           m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);

  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH,
    S_FIN
  } state_t;

  state_t               state, state_next;
  logic [LEN_WIDTH-1:0] rem, rem_next;
  logic                 phase, phase_next;
  logic [31:0]          tdata_next;

  // Next-state and datapath; fifo_rd_en is the only combinational output.
  always_comb begin
    state_next = state;
    rem_next   = rem;
    phase_next = phase;
    tdata_next = m_tdata;
    fifo_rd_en = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          if (num_samples != '0) begin
            rem_next   = num_samples;
            phase_next = 1'b0;
            tdata_next = '0;
            state_next = S_REQ;
          end else begin
            state_next = S_FIN;
          end
        end
      end
      S_REQ: begin
        fifo_rd_en = fifo_not_empty;
        if (fifo_not_empty) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (phase) tdata_next = {HALF_W'(fifo_dout), m_tdata[15:0]};
        else       tdata_next = {m_tdata[31:16], HALF_W'(fifo_dout)};
        rem_next   = rem - LEN_WIDTH'(1);
        phase_next = ~phase;
        if (phase || rem == LEN_WIDTH'(1)) state_next = S_PUSH;
        else                               state_next = S_REQ;
      end
      S_PUSH: begin
        if (m_tready) begin
          tdata_next = '0;
          phase_next = 1'b0;
          state_next = (rem == '0) ? S_FIN : S_REQ;
        end
      end
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase

    // Abort wins over everything; a sample held in WAIT is dropped with the word.
    if (abort && state != S_IDLE) begin
      state_next = S_IDLE;
      rem_next   = '0;
      phase_next = 1'b0;
      tdata_next = '0;
      fifo_rd_en = 1'b0;
    end
  end

  // State, datapath and registered status outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rem      <= '0;
      phase    <= 1'b0;
      m_tdata  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else begin
      state    <= state_next;
      rem      <= rem_next;
      phase    <= phase_next;
      m_tdata  <= tdata_next;
      busy     <= (state_next != S_IDLE);
      done     <= (state_next == S_FIN);
      m_tvalid <= (state_next == S_PUSH);
      m_tlast  <= (state_next == S_PUSH) && (rem_next == '0);
    end
  end

endmodule

// File: tb/tb_adc_fifo_drain_packer.sv
// Directed bench for adc_fifo_drain_packer: vector table of captures plus
// hand sequences for latency, backpressure, FIFO underrun and abort.
module tb_adc_fifo_drain_packer;

  localparam int unsigned DW = 12;
  localparam int unsigned LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] num_samples;
  logic          abort;
  logic          busy;
  logic          done;
  logic          fifo_not_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic [31:0]   m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;

  adc_fifo_drain_packer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .abort(abort),
    .busy(busy), .done(done), .fifo_not_empty(fifo_not_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast)
  );

  always #5 clk = ~clk;

  // FIFO model: standard read mode, data one cycle after the read strobe.
  logic [DW-1:0] mem [0:63];
  int            wr_cnt = 0;
  int            rd_ptr = 0;
  assign fifo_not_empty = (rd_ptr < wr_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  // Cumulative event monitor.
  int          rd_cnt = 0, done_cnt = 0, valid_cnt = 0, word_cnt = 0;
  logic [31:0] words [0:63];
  logic        lasts [0:63];

  always @(posedge clk) begin
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (m_tvalid) valid_cnt <= valid_cnt + 1;
    if (m_tvalid && m_tready) begin
      words[word_cnt % 64] <= m_tdata;
      lasts[word_cnt % 64] <= m_tlast;
      word_cnt             <= word_cnt + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [DW-1:0] v);
    mem[wr_cnt % 64] = v;
    wr_cnt++;
  endtask

  // Drive a start pulse; returns just after the edge that samples it.
  task automatic kick(input logic [LW-1:0] n);
    @(negedge clk);
    start       = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  typedef struct {
    logic [LW-1:0]        num;
    logic [3:0][DW-1:0]   s;
    int                   nwords;
    logic [1:0][31:0]     w;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int rd0, dn0, wc0, vc0;
    logic [31:0] held;

    vecs[0] = '{num: 16'd4, s: {12'h004, 12'h003, 12'h002, 12'h001}, nwords: 2,
                w: {32'h0004_0003, 32'h0002_0001}};
    vecs[1] = '{num: 16'd3, s: {12'h000, 12'hFFF, 12'h123, 12'hABC}, nwords: 2,
                w: {32'h0000_0FFF, 32'h0123_0ABC}};
    vecs[2] = '{num: 16'd0, s: '0, nwords: 0, w: '0};
    vecs[3] = '{num: 16'd1, s: {12'h000, 12'h000, 12'h000, 12'h7FF}, nwords: 1,
                w: {32'h0, 32'h0000_07FF}};
    vecs[4] = '{num: 16'd2, s: {12'h000, 12'h000, 12'h800, 12'hFFF}, nwords: 1,
                w: {32'h0, 32'h0800_0FFF}};

    rst = 1'b1; start = 1'b0; abort = 1'b0; num_samples = '0; m_tready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_rd_en", 32'(fifo_rd_en), 0);

    // Table of complete captures with m_tready held high.
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < int'(vecs[i].num); j++) load(vecs[i].s[j]);
      rd0 = rd_cnt; dn0 = done_cnt; wc0 = word_cnt; vc0 = valid_cnt;
      kick(vecs[i].num);
      if (vecs[i].num == '0) chk("zero_done_next_cycle", 32'(done), 1);
      wait_done("vec_done");
      repeat (2) @(negedge clk);
      chk("vec_reads", 32'(rd_cnt - rd0), 32'(vecs[i].num));
      chk("vec_done_pulses", 32'(done_cnt - dn0), 1);
      chk("vec_word_count", 32'(word_cnt - wc0), 32'(vecs[i].nwords));
      chk("vec_valid_cycles", 32'(valid_cnt - vc0), 32'(vecs[i].nwords));
      chk("vec_idle_after", 32'(busy), 0);
      for (int k = 0; k < vecs[i].nwords; k++) begin
        chk("vec_word", words[(wc0 + k) % 64], vecs[i].w[k]);
        chk("vec_tlast", 32'(lasts[(wc0 + k) % 64]), 32'(k == vecs[i].nwords - 1));
      end
    end

    // Cycle-exact latency for a 2-sample capture.
    load(12'h111); load(12'h222);
    kick(16'd2);
    chk("lat_c1_rd_en", 32'(fifo_rd_en), 1);
    chk("lat_c1_busy", 32'(busy), 1);
    @(negedge clk);
    chk("lat_c2_rd_en", 32'(fifo_rd_en), 0);
    repeat (2) @(negedge clk);
    chk("lat_c4_tvalid", 32'(m_tvalid), 0);
    @(negedge clk);
    chk("lat_c5_tvalid", 32'(m_tvalid), 1);
    chk("lat_c5_tdata", m_tdata, 32'h0222_0111);
    chk("lat_c5_tlast", 32'(m_tlast), 1);
    @(negedge clk);
    chk("lat_c6_done", 32'(done), 1);
    chk("lat_c6_tvalid", 32'(m_tvalid), 0);
    @(negedge clk);
    chk("lat_c7_done", 32'(done), 0);
    chk("lat_c7_busy", 32'(busy), 0);

    // Backpressure: hold the word for 10 cycles.
    m_tready = 1'b0;
    load(12'h0AA); load(12'h0BB);
    rd0 = rd_cnt; wc0 = word_cnt;
    kick(16'd2);
    begin
      int cyc = 0;
      while (m_tvalid !== 1'b1 && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("bp_tvalid", 32'(m_tvalid), 1);
    held = m_tdata;
    chk("bp_word", held, 32'h00BB_00AA);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_tdata_stable", m_tdata, 32'h00BB_00AA);
      chk("bp_tvalid_held", 32'(m_tvalid), 1);
    end
    chk("bp_reads", 32'(rd_cnt - rd0), 2);
    m_tready = 1'b1;
    wait_done("bp_done");
    @(negedge clk);
    chk("bp_accepted_once", 32'(word_cnt - wc0), 1);
    chk("bp_accepted_word", words[wc0 % 64], 32'h00BB_00AA);

    // FIFO runs dry after the first of two samples.
    load(12'h345);
    rd0 = rd_cnt; wc0 = word_cnt; vc0 = valid_cnt;
    kick(16'd2);
    repeat (6) @(negedge clk);
    chk("gap_reads", 32'(rd_cnt - rd0), 1);
    chk("gap_no_valid", 32'(valid_cnt - vc0), 0);
    chk("gap_busy", 32'(busy), 1);
    chk("gap_rd_en_low", 32'(fifo_rd_en), 0);
    load(12'h678);
    wait_done("gap_done");
    @(negedge clk);
    chk("gap_word_count", 32'(word_cnt - wc0), 1);
    chk("gap_word", words[wc0 % 64], 32'h0678_0345);
    chk("gap_tlast", 32'(lasts[wc0 % 64]), 1);

    // Abort and start together in IDLE: start ignored.
    load(12'h011); load(12'h022); load(12'h033); load(12'h044);
    rd0 = rd_cnt;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; num_samples = 16'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 0);
    @(negedge clk);
    chk("idle_abort_reads", 32'(rd_cnt - rd0), 0);

    // Abort while in WAIT drops the sample just read.
    dn0 = done_cnt; vc0 = valid_cnt; rd0 = rd_cnt;
    kick(16'd4);
    chk("ab_rd_en", 32'(fifo_rd_en), 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_tvalid", 32'(m_tvalid), 0);
    chk("ab_tdata", m_tdata, 0);
    repeat (4) @(negedge clk);
    chk("ab_no_done", 32'(done_cnt - dn0), 0);
    chk("ab_no_valid", 32'(valid_cnt - vc0), 0);
    chk("ab_reads", 32'(rd_cnt - rd0), 1);

    wc0 = word_cnt; dn0 = done_cnt;
    kick(16'd2);
    wait_done("ab_restart_done");
    @(negedge clk);
    chk("ab_restart_words", 32'(word_cnt - wc0), 1);
    chk("ab_restart_word", words[wc0 % 64], 32'h0033_0022);
    chk("ab_restart_done_pulses", 32'(done_cnt - dn0), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
